// File: rtl/lane_mem_pkg.sv
// lane_mem_pkg: shared encodings and elaboration helpers for lane_shared_wr_mem
package lane_mem_pkg;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int RDW_OLD   = 0;
    localparam int RDW_NEW   = 1;

    // Never returns 0 so single-entry parameters still give legal vector widths
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter: fixed-priority or round-robin one-hot grant over the write channels
module wr_port_arbiter
    import lane_mem_pkg::*;
#(
    parameter int NWR      = 3,
    parameter int ARB_MODE = ARB_FIXED,
    localparam int IW      = clog2(NWR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NWR-1:0] valid,
    output logic [NWR-1:0] grant,
    output logic [IW-1:0]  idx
);
    logic [IW-1:0] rr;
    logic          found;
    int            j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        if (!rst) begin
            for (int k = 0; k < NWR; k++) begin
                j = (ARB_MODE == ARB_RR) ? (int'(rr) + k) % NWR : k;
                if (!found && valid[j]) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr <= '0;
        else if (found) rr <= IW'((int'(idx) + 1) % NWR);
    end
endmodule

// File: rtl/lane_shared_wr_mem.sv
// lane_shared_wr_mem: NWR arbitrated partial-width lane writers sharing one write port,
// plus one registered read port with selectable read-during-write behaviour.
module lane_shared_wr_mem
    import lane_mem_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 32,
    parameter int LANE_W   = 8,
    parameter int WR_LANES = 2,
    parameter int NWR      = 3,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int RDW_MODE = RDW_OLD,
    localparam int AW      = clog2(DEPTH),
    localparam int NLANES  = DATA_W / LANE_W,
    localparam int LW      = clog2(NLANES),
    localparam int CW      = WR_LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_valid,
    output logic [NWR-1:0]    wr_ready,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*LW-1:0] wr_lane,
    input  logic [NWR*CW-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    localparam int  IW   = clog2(NWR);
    localparam bit  FULL = ((1 << AW) == DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     gidx;
    logic [AW-1:0]     waddr;
    logic [LW-1:0]     wlane;
    logic [CW-1:0]     wdata;
    logic [DATA_W-1:0] wword, wmask, rword, rnext;
    logic              we, rd_ok;

    wr_port_arbiter #(.NWR(NWR), .ARB_MODE(ARB_MODE)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (wr_valid),
        .grant (wr_ready),
        .idx   (gidx)
    );

    // Left shift drops lanes past the top of the word, which is the required clipping
    always_comb begin
        waddr = wr_addr[gidx*AW +: AW];
        wlane = wr_lane[gidx*LW +: LW];
        wdata = wr_data[gidx*CW +: CW];
        wword = DATA_W'(wdata) << (int'(wlane) * LANE_W);
        wmask = DATA_W'({CW{1'b1}}) << (int'(wlane) * LANE_W);
        we    = (|wr_ready) && (FULL || ({1'b0, waddr} < (AW+1)'(DEPTH)));
        rd_ok = FULL || ({1'b0, rd_addr} < (AW+1)'(DEPTH));
        rword = rd_ok ? mem[rd_addr] : '0;
        rnext = (RDW_MODE == RDW_NEW && we && waddr == rd_addr) ? ((rword & ~wmask) | (wword & wmask)) : rword;
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NLANES; l++)
            if (we && wmask[l*LANE_W]) mem[waddr][l*LANE_W +: LANE_W] <= wword[l*LANE_W +: LANE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rnext;
        end
    end
endmodule

// File: tb/tb_lane_shared_wr_mem.sv
// tb_lane_shared_wr_mem: directed checks of a fixed/old-data and a round-robin/new-data instance
module tb_lane_shared_wr_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wr_valid;
    logic [2:0]  ready0, ready1;
    logic [11:0] wr_addr;
    logic [5:0]  wr_lane;
    logic [47:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd0, rd1;
    logic        rv0, rv1;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    lane_shared_wr_mem #(.ARB_MODE(0), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready0), .wr_addr(wr_addr),
        .wr_lane(wr_lane), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd0), .rd_valid(rv0)
    );

    lane_shared_wr_mem #(.ARB_MODE(1), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready1), .wr_addr(wr_addr),
        .wr_lane(wr_lane), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd1), .rd_valid(rv1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [3:0] a, input logic [1:0] l, input logic [15:0] d);
        wr_addr[i*4 +: 4]  = a;
        wr_lane[i*2 +: 2]  = l;
        wr_data[i*16 +: 16] = d;
    endtask

    task automatic wr1(input int i, input logic [3:0] a, input logic [1:0] l, input logic [15:0] d);
        set_ch(i, a, l, d);
        wr_valid = 3'b001 << i;
        tick();
        wr_valid = 3'b000;
    endtask

    initial begin
        rst = 1'b1; wr_valid = '0; wr_addr = '0; wr_lane = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        chk("reset_rv0", 32'(rv0), 32'h0);
        chk("reset_rd0", rd0, 32'h0);
        chk("reset_rv1", 32'(rv1), 32'h0);
        chk("reset_rd1", rd1, 32'h0);
        rst = 1'b0;

        set_ch(0, 4'd2, 2'd0, 16'h0101);
        set_ch(1, 4'd2, 2'd1, 16'h0202);
        set_ch(2, 4'd2, 2'd2, 16'h0303);
        wr_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("fixed_prio_c%0d", c), 32'(ready0), 32'b001);
            chk($sformatf("rr_seq_c%0d", c), 32'(ready1), 32'(3'b001 << (c % 3)));
            tick();
        end
        wr_valid = 3'b110;
        #1;
        chk("fixed_drop_ch0", 32'(ready0), 32'b010);
        chk("rr_drop_ch0", 32'(ready1), 32'b010);
        tick();
        wr_valid = 3'b000;

        wr1(0, 4'd5, 2'd0, 16'h0000);
        wr1(0, 4'd5, 2'd2, 16'h0000);
        wr1(0, 4'd5, 2'd0, 16'hBEEF);
        wr1(1, 4'd5, 2'd1, 16'h1234);
        wr1(2, 4'd5, 2'd3, 16'hAB99);
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        rd_en = 1'b0;
        chk("merge_rd0", rd0, 32'h9912_34EF);
        chk("merge_rd1", rd1, 32'h9912_34EF);
        chk("merge_rv0", 32'(rv0), 32'h1);

        wr1(0, 4'd7, 2'd0, 16'h1111);
        wr1(0, 4'd7, 2'd2, 16'h1111);
        set_ch(0, 4'd7, 2'd0, 16'hFFFF);
        wr_valid = 3'b001; rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        wr_valid = 3'b000;
        chk("rdw_old", rd0, 32'h1111_1111);
        chk("rdw_new", rd1, 32'h1111_FFFF);
        tick();
        rd_en = 1'b0;
        chk("after_write_rd0", rd0, 32'h1111_FFFF);
        chk("after_write_rd1", rd1, 32'h1111_FFFF);

        wr1(0, 4'd3, 2'd0, 16'hCAFE);
        wr1(0, 4'd3, 2'd2, 16'h5A5A);
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0; rd_addr = 4'd5;
        chk("hold_rv_pulse", 32'(rv0), 32'h1);
        chk("hold_rd", rd0, 32'h5A5A_CAFE);
        tick();
        chk("hold_rv_low1", 32'(rv0), 32'h0);
        chk("hold_rd_stable1", rd0, 32'h5A5A_CAFE);
        tick();
        chk("hold_rv_low2", 32'(rv1), 32'h0);
        chk("hold_rd_stable2", rd1, 32'h5A5A_CAFE);

        wr1(1, 4'd10, 2'd0, 16'h0000);
        set_ch(1, 4'd5, 2'd0, 16'h0000);
        set_ch(2, 4'd5, 2'd2, 16'h0000);
        wr_valid = 3'b110; rd_en = 1'b1; rd_addr = 4'd5; rst = 1'b1;
        #1;
        chk("rst_ready0", 32'(ready0), 32'h0);
        chk("rst_ready1", 32'(ready1), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("rst_rv_c%0d", c), 32'(rv1), 32'h0);
            chk($sformatf("rst_rd_c%0d", c), rd1, 32'h0);
            chk($sformatf("rst_ready_c%0d", c), 32'(ready1), 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_fixed_grant", 32'(ready0), 32'b010);
        chk("post_rst_rr_grant", 32'(ready1), 32'b010);
        tick();
        chk("post_rst_mem_old", rd0, 32'h9912_34EF);
        chk("post_rst_mem_new", rd1, 32'h9912_0000);
        chk("post_rst_rv", 32'(rv0), 32'h1);
        #1;
        chk("post_rst_rr_next", 32'(ready1), 32'b100);
        wr_valid = 3'b000; rd_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lane_shared_wr_mem.md
# lane_shared_wr_mem

Parametrised synchronous memory that merges NWR independent partial-width write channels onto one physical write port and serves one registered read port. Each channel writes a contiguous group of lanes at a runtime-selected lane offset. A fixed-priority or round-robin arbiter grants one channel per cycle through a valid/ready handshake, so losing channels stall instead of being dropped. The block sits in the memory-inference test set as the generalised successor of the fixed three-port shared-write memory.

## Interface
- DEPTH, 16: number of words; AW = clog2(DEPTH)
- DATA_W, 32: word width; must be a multiple of LANE_W
- LANE_W, 8: lane granularity; NLANES = DATA_W/LANE_W; LW = clog2(NLANES)
- WR_LANES, 2: lanes per write channel; channel data width CW = WR_LANES*LANE_W
- NWR, 3: number of write channels (1..8)
- ARB_MODE, 0: 0 = fixed priority (channel 0 highest), 1 = round-robin
- RDW_MODE, 0: read-during-write to the same address; 0 = old data, 1 = new merged data

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  NWR  per-channel write request
- wr_ready  out  NWR  per-channel grant; one-hot or zero
- wr_addr  in  NWR*AW  packed word addresses; channel i at [i*AW +: AW]
- wr_lane  in  NWR*LW  packed starting lane index per channel
- wr_data  in  NWR*CW  packed write data; LSB lands in lane wr_lane
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  high exactly one cycle after an accepted rd_en

## Operation
- Handshake: a write commits on the rising edge where wr_valid[i] && wr_ready[i]. A requester holds valid, addr, lane, and data stable until it is granted.
- Arbiter, fixed mode: grants the lowest-index valid channel.
- Arbiter, round-robin mode: searches upward from pointer rr (wrapping) and grants the first valid channel. After a grant, rr = granted index + 1 mod NWR. rr does not change in cycles with no grant.
- Lane write: lanes wr_lane .. wr_lane+WR_LANES-1 of mem[wr_addr] receive the data. Any lane index >= NLANES is discarded, with no wrap. Example: lane 3 with WR_LANES = 2 writes lane 3 only. Unwritten lanes keep their value.
- Read: when rd_en is high, rd_data <= mem[rd_addr] (or the RDW-merged value) and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds.
- Read-during-write to the same address: with RDW_MODE = 0, rd_data returns the pre-write word. With RDW_MODE = 1, rd_data returns the pre-write word with the granted lanes replaced by the write data.
- Reset: rd_data = 0, rd_valid = 0, rr = 0, and wr_ready = 0 while rst is high. No write commits and no read is accepted during reset. Memory contents are not cleared.
- Out-of-range addresses (>= DEPTH when DEPTH is not a power of 2): a write is granted but has no effect; a read returns 0.

## Timing
- Grant is combinational from wr_valid and rr, in the same cycle; no bubble between back-to-back grants.
- Write latency: data is visible to a read issued in the next cycle, or in the same cycle when RDW_MODE = 1.
- Read latency: 1 cycle, rd_en to rd_data/rd_valid.
- Throughput: 1 write plus 1 read per cycle.
- Reset asserted mid-stream: pending requests stay ungranted; rr restarts at 0 on the first cycle after reset.

## Structure
- Shared package lane_mem_pkg holds:
  - ARB_FIXED/ARB_RR and RDW_OLD/RDW_NEW encodings
  - the clog2 function
- Sub-module wr_port_arbiter (NWR, ARB_MODE): takes wr_valid, rst, and clk; produces the one-hot grant and the grant index; owns rr.
- Top module: lane mask/shift, storage array, read register, RDW merge.

## Test plan
- Priority, fixed mode: all 3 channels valid on addr 2 with lanes 0, 1, 2 for 3 cycles. Required: grants in order ch0, ch0, ch0 with ch1/ch2 stalled. Drop ch0; then ch1 is granted.
- Round-robin: all 3 channels valid continuously with ARB_MODE = 1. Required: grant sequence 0, 1, 2, 0, 1, 2.
- Lane merge: mem[5] = 0 is written by ch0 lane 0 = 16'hBEEF, then ch1 lane 1 = 16'h1234, then ch2 lane 3 = 16'hAB99. Read addr 5 -> 32'h9912_34EF. Only 8'h99 of the ch2 data lands; lane 3 clips.
- RDW: mem[7] = 32'h1111_1111, then a same-cycle write of ch0 lane 0 = 16'hFFFF with a read of addr 7. Required: RDW_MODE = 0 -> 32'h1111_1111; RDW_MODE = 1 -> 32'h1111_FFFF.
- Reset mid-operation: assert rst while ch1 and ch2 are valid. Required: wr_ready = 0, rd_valid = 0, rd_data = 0 during reset, and no memory change. After release in RR mode, ch1 is granted first.
- Read hold: rd_en pulses once at addr 3, then stays low. Required: rd_valid is high for exactly 1 cycle and rd_data stays stable afterwards.
